mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the pipeline's instruction-fetch port and its MEM-stage load/store port.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_timer.sv | 31 +++
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM states. The encodings are fixed so waveforms stay readable.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUSY = 3'd1,
        DBUSY = 3'd2,
        IDROP = 3'd3,
        RESP  = 3'd4
    } arb_state_t;

    // Data word returned to the owning port when the memory never answers.
    localparam logic [31:0] ERROR_WORD = 32'hDEADBEEF;

    // True in every state where a memory transaction is outstanding.
    function automatic logic holds_memory(input arb_state_t s);
        return (s == IBUSY) || (s == DBUSY) || (s == IDROP);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter for outstanding memory transactions. It is cleared on
// every state change and counts while enabled, stopping at its terminal
// count so the expired flag stays stable until it is cleared.
module mem_arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT - 1));

    // Count cycles spent waiting on the memory; clear wins over enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// MEM-stage load/store port. Data wins by default; a starvation counter
// forces one fetch grant after STARVE_MAX consecutive fetch losses, and a
// watchdog aborts transactions the memory never acknowledges.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        flush,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        err_timeout
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state;
    arb_state_t    next_state;
    logic [SW-1:0] starve_cnt;
    logic          starve_full;
    logic          resp_fetch;
    logic [31:0]   rdata_q;
    logic          d_req;
    logic          fetch_ok;
    logic          grant_fetch;
    logic          grant_data;
    logic          capture;
    logic          timed_out;
    logic          drop_req;
    logic          expired;
    logic          timer_clear;
    logic          timer_enable;

    assign d_req       = d_read | d_write;
    assign fetch_ok    = if_req & ~flush;
    assign starve_full = (starve_cnt == SW'(STARVE_MAX));

    // Next-state logic and per-cycle control strobes for the datapath.
    always_comb begin
        next_state  = state;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        capture     = 1'b0;
        timed_out   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(fetch_ok && starve_full)) begin
                    grant_data = 1'b1;
                    next_state = DBUSY;
                end else if (fetch_ok) begin
                    grant_fetch = 1'b1;
                    next_state  = IBUSY;
                end
            end
            IBUSY: begin
                if (mem_ack) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    next_state = RESP;
                end else if (flush) begin
                    next_state = IDROP;
                end
            end
            DBUSY: begin
                if (mem_ack) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    next_state = RESP;
                end
            end
            IDROP: begin
                if (mem_ack) begin
                    next_state = IDLE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The request is withdrawn whenever an outstanding transaction ends.
    assign drop_req     = holds_memory(state) && !holds_memory(next_state);
    assign timer_clear  = (next_state != state);
    assign timer_enable = holds_memory(state);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory request registers, loaded on a grant and released on completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_fetch <= 1'b0;
        end else if (grant_data) begin
            mem_req    <= 1'b1;
            mem_we     <= d_write;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            resp_fetch <= 1'b0;
        end else if (grant_fetch) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            resp_fetch <= 1'b1;
        end else if (drop_req) begin
            mem_req    <= 1'b0;
        end
    end

    // Response data and the sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (capture) begin
                rdata_q <= mem_rdata;
            end else if (timed_out && state != IDROP) begin
                rdata_q <= ERROR_WORD;
            end
            if (timed_out) begin
                err_timeout <= 1'b1;
            end
        end
    end

    // Starvation counter: counts data grants that a waiting fetch lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant_fetch) begin
            starve_cnt <= '0;
        end else if (grant_data && if_req && !starve_full) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign if_done  = (state == RESP) & resp_fetch & ~flush;
    assign d_done   = (state == RESP) & ~resp_fetch;
    assign if_rdata = rdata_q;
    assign d_rdata  = rdata_q;
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with hand-computed values.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err_timeout;

    int check_count = 0;
    int error_count = 0;

    mem_arbiter #(
        .STARVE_MAX (4),
        .TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .flush       (flush),
        .if_rdata    (if_rdata),
        .if_done     (if_done),
        .if_stall    (if_stall),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_done      (d_done),
        .d_stall     (d_stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .err_timeout (err_timeout)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected sequence end");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic f_req, input logic [31:0] f_addr, input logic f_flush,
                                 input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if_req  = f_req;
        if_addr = f_addr;
        flush   = f_flush;
        d_read  = rd;
        d_write = wr;
        d_addr  = addr;
        d_wdata = wdata;
    endtask

    task automatic advanceCycle();
        @(posedge clk);
        #1;
    endtask

    int cycles;

    initial begin
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        advanceCycle();
        advanceCycle();
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_if_done", if_done, 0);
        checkOutput("rst_d_done", d_done, 0);
        checkOutput("rst_err", err_timeout, 0);
        reset = 1'b1;
        advanceCycle();

        // 1. Fetch only, ack one cycle after the request.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        advanceCycle();
        checkOutput("f_mem_req", mem_req, 1);
        checkOutput("f_mem_addr", mem_addr, 32'h10);
        checkOutput("f_mem_we", mem_we, 0);
        checkOutput("f_mem_wdata", mem_wdata, 0);
        checkOutput("f_if_stall_busy", if_stall, 1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        advanceCycle();
        mem_ack = 1'b0;
        checkOutput("f_req_drop", mem_req, 0);
        checkOutput("f_if_done", if_done, 1);
        checkOutput("f_if_rdata", if_rdata, 32'h1234_5678);
        checkOutput("f_if_stall_done", if_stall, 0);
        checkOutput("f_d_done", d_done, 0);
        if_req = 1'b0;
        advanceCycle();
        checkOutput("f_done_pulse", if_done, 0);

        // 2. Fetch and load together: data first, fetch right after RESP.
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        advanceCycle();
        checkOutput("p_addr", mem_addr, 32'h40);
        checkOutput("p_we", mem_we, 0);
        checkOutput("p_d_stall", d_stall, 1);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        advanceCycle();
        mem_ack = 1'b0;
        checkOutput("p_d_done", d_done, 1);
        checkOutput("p_d_rdata", d_rdata, 32'hAAAA_5555);
        checkOutput("p_if_done", if_done, 0);
        d_read = 1'b0;
        advanceCycle();
        checkOutput("p_resp_no_grant", mem_req, 0);
        advanceCycle();
        checkOutput("p_fetch_req", mem_req, 1);
        checkOutput("p_fetch_addr", mem_addr, 32'h20);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        advanceCycle();
        mem_ack = 1'b0;
        checkOutput("p_fetch_done", if_done, 1);
        if_req = 1'b0;
        advanceCycle();

        // 3. Continuous store plus fetch: fetch wins the 5th arbitration.
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b1, 32'h80, 32'h55);
        for (int i = 0; i < 5; i++) begin
            advanceCycle();
            checkOutput($sformatf("s_addr%0d", i), mem_addr, (i < 4) ? 32'h80 : 32'h30);
            checkOutput($sformatf("s_we%0d", i), mem_we, (i < 4) ? 1 : 0);
            mem_ack = 1'b1; mem_rdata = i;
            advanceCycle();
            mem_ack = 1'b0;
            if (i < 4) checkOutput($sformatf("s_d_done%0d", i), d_done, 1);
            else       checkOutput("s_if_done", if_done, 1);
            advanceCycle();
        end
        advanceCycle();
        checkOutput("s_cnt_cleared_we", mem_we, 1);
        checkOutput("s_cnt_cleared_addr", mem_addr, 32'h80);
        mem_ack = 1'b1;
        advanceCycle();
        mem_ack = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        advanceCycle();

        // 4. Flush while fetching: request held until ack, no if_done.
        applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        advanceCycle();
        checkOutput("fl_req", mem_req, 1);
        flush = 1'b1; if_req = 1'b0;
        advanceCycle();
        flush = 1'b0;
        checkOutput("fl_held1", mem_req, 1);
        advanceCycle();
        checkOutput("fl_held2", mem_req, 1);
        advanceCycle();
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        advanceCycle();
        mem_ack = 1'b0;
        checkOutput("fl_drop", mem_req, 0);
        checkOutput("fl_no_done", if_done, 0);
        advanceCycle();
        checkOutput("fl_idle_done", if_done, 0);
        checkOutput("fl_idle_req", mem_req, 0);
        applyStimulus(1'b1, 32'h48, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        advanceCycle();
        checkOutput("fl_same_cycle", mem_req, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        advanceCycle();

        // 5. No ack: abort after 64 cycles with the error word.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h90, 32'h0);
        advanceCycle();
        checkOutput("to_req", mem_req, 1);
        cycles = 0;
        while (mem_req && cycles < 200) begin
            advanceCycle();
            cycles++;
        end
        checkOutput("to_cycles", cycles, 64);
        checkOutput("to_err", err_timeout, 1);
        checkOutput("to_d_done", d_done, 1);
        checkOutput("to_rdata", d_rdata, 32'hDEADBEEF);
        d_read = 1'b0;
        advanceCycle();
        checkOutput("to_sticky", err_timeout, 1);

        // Ack on the expiry cycle is an ordinary completion.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h94, 32'h0);
        advanceCycle();
        for (int j = 0; j < 63; j++) advanceCycle();
        checkOutput("te_still_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
        advanceCycle();
        mem_ack = 1'b0;
        checkOutput("te_done", d_done, 1);
        checkOutput("te_rdata", d_rdata, 32'h0000_0077);
        d_read = 1'b0;
        advanceCycle();

        // 6. Reset in the middle of a store, then a stale ack.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC0, 32'h1);
        advanceCycle();
        checkOutput("mr_req", mem_req, 1);
        reset = 1'b0;
        #1;
        checkOutput("mr_req_drop", mem_req, 0);
        checkOutput("mr_addr", mem_addr, 0);
        checkOutput("mr_we", mem_we, 0);
        checkOutput("mr_err", err_timeout, 0);
        d_write = 1'b0;
        advanceCycle();
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        advanceCycle();
        mem_ack = 1'b0;
        checkOutput("mr_late_d_done", d_done, 0);
        checkOutput("mr_late_if_done", if_done, 0);
        checkOutput("mr_late_req", mem_req, 0);
        advanceCycle();
        checkOutput("mr_after_d_done", d_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
